// File: rtl/mpmc11_pkg.sv
// Shared types and constants for the mpmc11 FIFO family.
package mpmc11_pkg;

    typedef enum logic [0:0] {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_t;

    localparam int MPMC11_FIFO_DEP_DEFAULT = 32;

    // Wishbone write request carried through the FIFO as a flat word.
    typedef struct packed {
        logic [31:0]  adr;
        logic [127:0] dat;
        logic [15:0]  sel;
    } wb_write_request128_t;

    localparam int MPMC11_WBREQ_WID = $bits(wb_write_request128_t);

endpackage

// File: rtl/mpmc11_fifo_ram.sv
// FIFO storage: DEP x WID array, synchronous write, asynchronous read, no reset.
module mpmc11_fifo_ram
    import mpmc11_pkg::*;
#(
    parameter int WID = 256,
    parameter int DEP = MPMC11_FIFO_DEP_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [$clog2(DEP)-1:0] waddr_i,
    input  logic [WID-1:0]         wdata_i,
    input  logic [$clog2(DEP)-1:0] raddr_i,
    output logic [WID-1:0]         rdata_o
);

    logic [WID-1:0] mem_q [DEP];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mpmc11_fifo.sv
// Single-clock FIFO with registered status flags, high-water mark and
// selectable registered-read or first-word-fall-through output.
module mpmc11_fifo
    import mpmc11_pkg::*;
#(
    parameter int         WID           = 256,
    parameter int         DEP           = MPMC11_FIFO_DEP_DEFAULT,
    parameter fifo_mode_t MODE          = FIFO_STD,
    parameter int         AFULL_THRESH  = DEP - 2,
    parameter int         AEMPTY_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 wr_fifo,
    input  logic [WID-1:0]       din,
    input  logic                 rd_fifo,
    output logic [WID-1:0]       dout,
    output logic                 v,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 overflow,
    output logic                 underflow,
    output logic [$clog2(DEP):0] cnt,
    output logic [$clog2(DEP):0] hwm
);

    localparam int AW = $clog2(DEP);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEP_C = CW'(DEP);
    localparam logic [CW-1:0] AF_C  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C  = CW'(AEMPTY_THRESH);

    logic [AW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]  cnt_q, cnt_d, hwm_q, hwm_d;
    logic           full_q, empty_q, afull_q, aempty_q;
    logic           ovf_q, ovf_d, unf_q, unf_d, v_q, v_d;
    logic [WID-1:0] dout_q, dout_d, rd_data;
    logic           wr_acc, rd_acc;

    // Acceptance uses the registered flags, so a full FIFO never writes through
    // and an empty one never reads through; clr masks both.
    assign wr_acc = wr_fifo & ~full_q  & ~clr;
    assign rd_acc = rd_fifo & ~empty_q & ~clr;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        hwm_d  = hwm_q;
        v_d    = 1'b0;
        dout_d = dout_q;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            hwm_d  = '0;
        end else begin
            ovf_d = wr_fifo & full_q;
            unf_d = rd_fifo & empty_q;
            if (wr_acc) wptr_d = wptr_q + 1'b1;
            if (rd_acc) rptr_d = rptr_q + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            if (cnt_d > hwm_q) hwm_d = cnt_d;
            if ((MODE == FIFO_STD) && rd_acc) begin
                v_d    = 1'b1;
                dout_d = rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            hwm_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            v_q      <= 1'b0;
            dout_q   <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            hwm_q    <= hwm_d;
            full_q   <= (cnt_d == DEP_C);
            empty_q  <= (cnt_d == '0);
            afull_q  <= (cnt_d >= AF_C);
            aempty_q <= (cnt_d <= AE_C);
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            v_q      <= v_d;
            dout_q   <= dout_d;
        end
    end

    mpmc11_fifo_ram #(
        .WID (WID),
        .DEP (DEP)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wptr_q),
        .wdata_i (din),
        .raddr_i (rptr_q),
        .rdata_o (rd_data)
    );

    // FWFT shows the head word straight from the array; dout_q stays at its
    // reset value in that mode and covers the empty case.
    assign dout         = ((MODE == FIFO_FWFT) && !empty_q) ? rd_data : dout_q;
    assign v            = (MODE == FIFO_FWFT) ? ~empty_q : v_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign cnt          = cnt_q;
    assign hwm          = hwm_q;

endmodule

// File: tb/tb_mpmc11_fifo.sv
// Bench for mpmc11_fifo: STD and FWFT instances on a shared stimulus stream,
// compared every cycle against a queue-based model.
module tb_mpmc11_fifo;
    import mpmc11_pkg::*;

    localparam int WID = 8;
    localparam int DEP = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           clr = 1'b0;
    logic           wr_fifo = 1'b0;
    logic           rd_fifo = 1'b0;
    logic [WID-1:0] din = '0;

    logic [WID-1:0] dout_s, dout_f;
    logic           v_s, v_f, full_s, full_f, empty_s, empty_f;
    logic           af_s, af_f, ae_s, ae_f, ovf_s, ovf_f, unf_s, unf_f;
    logic [4:0]     cnt_s, cnt_f, hwm_s, hwm_f;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mpmc11_fifo #(.WID(WID), .DEP(DEP), .MODE(FIFO_STD), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u_std (
        .clk(clk), .rst(rst), .clr(clr), .wr_fifo(wr_fifo), .din(din), .rd_fifo(rd_fifo),
        .dout(dout_s), .v(v_s), .full(full_s), .empty(empty_s), .almost_full(af_s),
        .almost_empty(ae_s), .overflow(ovf_s), .underflow(unf_s), .cnt(cnt_s), .hwm(hwm_s));

    mpmc11_fifo #(.WID(WID), .DEP(DEP), .MODE(FIFO_FWFT), .AFULL_THRESH(14), .AEMPTY_THRESH(2)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .wr_fifo(wr_fifo), .din(din), .rd_fifo(rd_fifo),
        .dout(dout_f), .v(v_f), .full(full_f), .empty(empty_f), .almost_full(af_f),
        .almost_empty(ae_f), .overflow(ovf_f), .underflow(unf_f), .cnt(cnt_f), .hwm(hwm_f));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, outputs derived from occupancy.
    logic [7:0] mq[$];
    int         hwm_m = 0;
    logic       ovf_m = 1'b0, unf_m = 1'b0, vstd_m = 1'b0;
    logic [7:0] dstd_m = '0;
    bit         m_full, m_empty;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete(); hwm_m = 0; ovf_m = 0; unf_m = 0; vstd_m = 0; dstd_m = '0;
        end else if (clr) begin
            mq.delete(); hwm_m = 0; ovf_m = 0; unf_m = 0; vstd_m = 0;
        end else begin
            m_full  = (mq.size() == DEP);
            m_empty = (mq.size() == 0);
            ovf_m   = wr_fifo && m_full;
            unf_m   = rd_fifo && m_empty;
            vstd_m  = 1'b0;
            if (rd_fifo && !m_empty) begin
                dstd_m = mq.pop_front();
                vstd_m = 1'b1;
            end
            if (wr_fifo && !m_full) mq.push_back(din);
            if (mq.size() > hwm_m) hwm_m = mq.size();
        end
    end

    always @(negedge clk) begin
        logic [31:0] ce;
        logic [3:0]  fl;
        ce = 32'(mq.size());
        fl = {mq.size() == DEP, mq.size() == 0, mq.size() >= 14, mq.size() <= 2};
        chk("cnt_std", 32'(cnt_s), ce);
        chk("cnt_fwft", 32'(cnt_f), ce);
        chk("hwm_std", 32'(hwm_s), 32'(hwm_m));
        chk("hwm_fwft", 32'(hwm_f), 32'(hwm_m));
        chk("flags_std", 32'({full_s, empty_s, af_s, ae_s}), 32'(fl));
        chk("flags_fwft", 32'({full_f, empty_f, af_f, ae_f}), 32'(fl));
        chk("ovf_unf_std", 32'({ovf_s, unf_s}), 32'({ovf_m, unf_m}));
        chk("ovf_unf_fwft", 32'({ovf_f, unf_f}), 32'({ovf_m, unf_m}));
        chk("v_std", 32'(v_s), 32'(vstd_m));
        chk("dout_std", 32'(dout_s), 32'(dstd_m));
        chk("v_fwft", 32'(v_f), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("dout_fwft", 32'(dout_f), 32'(mq[0]));
    end

    task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic c);
        wr_fifo = w; din = d; rd_fifo = r; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] got[$];
        int wn, maxc, cyc;
        logic w, r;

        // Reset held with writes requested, then released idle.
        repeat (3) drive(1'b1, 8'h55, 1'b0, 1'b0);
        chk("rst_cnt", 32'(cnt_s), 0);
        chk("rst_empty", 32'(empty_s), 1);
        chk("rst_ae", 32'(ae_s), 1);
        chk("rst_dout_std", 32'(dout_s), 0);
        chk("rst_dout_fwft", 32'(dout_f), 0);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_cnt", 32'(cnt_f), 0);

        // Fill, overflow, full with simultaneous rd/wr, drain in order.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            if (i == 0)  chk("first_write_cnt", 32'(cnt_s), 1);
            if (i == 12) chk("af_13", 32'(af_s), 0);
            if (i == 13) chk("af_14", 32'(af_s), 1);
        end
        chk("full_16", 32'(full_s), 1);
        chk("cnt_16", 32'(cnt_s), 16);
        drive(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_pulse", 32'(ovf_s), 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("ovf_clear", 32'(ovf_s), 0);
        drive(1'b1, 8'hBB, 1'b1, 1'b0);
        chk("full_rw_ovf", 32'(ovf_f), 1);
        chk("full_rw_cnt", 32'(cnt_s), 15);
        chk("full_rw_dout", 32'(dout_s), 32'h00);
        for (int i = 1; i < 16; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_dout", 32'(dout_s), 32'(i));
        end
        chk("drained_empty", 32'(empty_s), 1);

        // Single registered read at cnt=3.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("std_v", 32'(v_s), 1);
        chk("std_dout", 32'(dout_s), 32'h30);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("std_v_drop", 32'(v_s), 0);
        chk("std_cnt2", 32'(cnt_s), 2);
        chk("std_ae", 32'(ae_s), 1);

        // Simultaneous rd/wr at cnt=5, then on empty.
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h33 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
        chk("rw_cnt5", 32'(cnt_s), 5);
        repeat (5) drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        chk("empty_rw_cnt", 32'(cnt_s), 1);
        chk("empty_rw_unf", 32'(unf_s), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_hwm", 32'(hwm_s), 0);

        // FWFT stream of 40 bytes with random backpressure.
        wn = 0; maxc = 0; cyc = 0;
        while ((wn < 40 || got.size() < 40) && cyc < 2000) begin
            w = (wn < 40) && ($urandom_range(3) != 0);
            r = 1'($urandom_range(1));
            if (r && v_f) got.push_back(dout_f);
            if (w && mq.size() < DEP) wn++;
            drive(w, 8'(wn - 1), r, 1'b0);
            if (int'(cnt_f) > maxc) maxc = int'(cnt_f);
            cyc++;
        end
        chk("fwft_count", 32'(got.size()), 40);
        foreach (got[i]) chk("fwft_order", 32'(got[i]), 32'(i));
        chk("fwft_hwm", 32'(hwm_f), 32'(maxc));

        // clr with rd and wr at cnt=9.
        for (int i = 0; i < 9; i++) drive(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        drive(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("clr_cnt", 32'(cnt_s), 0);
        chk("clr_hwm2", 32'(hwm_f), 0);
        chk("clr_empty", 32'(empty_s), 1);
        chk("clr_v_std", 32'(v_s), 0);
        chk("clr_v_fwft", 32'(v_f), 0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("clr_nowrite", 32'(cnt_f), 0);

        // Reset asserted mid-burst.
        for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        wr_fifo = 1'b1; din = 8'h11; rst = 1'b0;
        #2;
        chk("async_cnt", 32'(cnt_s), 0);
        chk("async_empty", 32'(empty_f), 1);
        chk("async_v", 32'(v_f), 0);
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("mid_rst_cnt", 32'(cnt_s), 0);
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("mid_rst_wr", 32'(cnt_s), 1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("mid_rst_rd", 32'(dout_s), 32'h5A);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mpmc11_fifo.md
MPMC11_FIFO -- requirements
Module: mpmc11_fifo

Interface
REQ-001 SHALL have parameter WID, default 256; data width in bits.
REQ-002 SHALL have parameter DEP, default 32; depth in words, a power of two from 4 to 256.
REQ-003 SHALL have parameter MODE, default FIFO_STD (fifo_mode_t); FIFO_STD gives 1-cycle registered read, FIFO_FWFT gives first-word-fall-through.
REQ-004 SHALL have parameter AFULL_THRESH, default DEP-2; almost_full asserts at cnt >= AFULL_THRESH.
REQ-005 SHALL have parameter AEMPTY_THRESH, default 2; almost_empty asserts at cnt <= AEMPTY_THRESH.
REQ-006 SHALL have ports, each given as name, direction, width, meaning:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush.
- wr_fifo  in  1  write request.
- din  in  WID  write data.
- rd_fifo  in  1  read request.
- dout  out  WID  read data.
- v  out  1  dout valid.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- overflow, underflow  out  1 each  one-cycle reject pulses.
- cnt  out  $clog2(DEP)+1  words stored, range 0..DEP inclusive.
- hwm  out  $clog2(DEP)+1  peak cnt since reset or clr.

Function
REQ-007 SHALL accept a write iff wr_fifo & ~full; accepted data SHALL be stored at wptr, and wptr SHALL advance modulo DEP.
REQ-008 SHALL accept a read iff rd_fifo & ~empty; rptr SHALL advance modulo DEP.
REQ-009 SHALL evaluate acceptance on the pre-edge flags, with no write-through when full and no read-through when empty.
REQ-010 SHALL update cnt the next edge: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-011 SHALL derive full = (cnt==DEP) and empty = (cnt==0); both flags SHALL be registered and consistent with cnt every cycle.
REQ-012 In FIFO_STD, an accepted read SHALL load dout with mem[rptr] at that edge, with v=1 for the following cycle only.
REQ-013 In FIFO_STD, dout SHALL hold its value when no read is accepted.
REQ-014 In FIFO_FWFT, dout SHALL continuously present the head word, v SHALL equal ~empty, and rd_fifo SHALL act as acknowledge.
REQ-015 SHALL pulse overflow for 1 cycle after a rejected write, and underflow for 1 cycle after a rejected read.
REQ-016 When full, simultaneous rd and wr SHALL accept the read, reject the write, and pulse overflow.
REQ-017 When empty, simultaneous rd and wr SHALL accept the write, reject the read, and pulse underflow.
REQ-018 hwm SHALL update to the post-edge cnt whenever that value exceeds hwm.
REQ-019 clr SHALL take priority over rd/wr in the same cycle: zero pointers, cnt and hwm, set empty, clear v, and leave dout unchanged.
REQ-020 SHALL preserve data order across pointer wrap-around.

Reset
REQ-021 While rst=0, SHALL force asynchronously: cnt=0, hwm=0, pointers=0, empty=1, full=0, almost_full=0, almost_empty=1, v=0, overflow=0, underflow=0, dout=0.
REQ-022 SHALL ignore rd_fifo/wr_fifo during reset, and accept a write on the first edge after rst deasserts.
REQ-023 Reset asserted mid-burst SHALL discard contents with no spurious v, overflow or underflow pulse after release.

Structure
REQ-024 SHALL import mpmc11_pkg, which holds the fifo_mode_t enum (FIFO_STD, FIFO_FWFT) and the constant MPMC11_FIFO_DEP_DEFAULT=32.
REQ-025 SHALL place storage in sub-module mpmc11_fifo_ram: DEP x WID, one synchronous write port, one asynchronous read port, no reset on the array.
REQ-026 SHALL remain vendor-primitive free, with an instance for the write-request type via WID=$bits(wb_write_request128_t).

Verification (WID=8, DEP=16, AFULL_THRESH=14, AEMPTY_THRESH=2)
REQ-027 Hold rst=0 with wr_fifo=1 for 3 cycles, then release -> during and after reset, all REQ-021 values, cnt=0, no write stored.
REQ-028 Write 0x00..0x0F on consecutive cycles, then a 17th write of 0xAA:
- almost_full asserts after the 14th write.
- full=1 and cnt=16 after the 16th write.
- overflow pulses 1 cycle after the 17th write.
- reading 16 words returns 0x00..0x0F and never 0xAA.
REQ-029 STD mode, cnt=3, assert rd_fifo 1 cycle -> next cycle v=1 with dout=head word, then v=0; cnt=2 and almost_empty=1.
REQ-030 With cnt=5, assert rd and wr together 4 cycles -> cnt stays 5. On empty, do the same -> write accepted, underflow pulse, cnt=1.
REQ-031 FWFT mode, write 40 incrementing bytes with random rd backpressure -> v==~empty every cycle, 40 bytes read in order across 2+ wraps, hwm equals the max cnt observed.
REQ-032 Assert clr together with rd and wr at cnt=9 -> next cycle cnt=0, hwm=0, empty=1, v=0, no write retained.
